// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: chooser encoding, branch-update bundle and
// reset values for the predictor's saturating counters.
package rv32i_types;

    typedef enum logic [1:0] {
        local_st  = 2'b00,
        local_lt  = 2'b01,
        global_lt = 2'b10,
        global_st = 2'b11
    } selector_t;

    localparam int unsigned BPRED_LHIST_BITS = 4;
    localparam int unsigned BPRED_GHIST_BITS = 8;

    // local/global are keywords, hence the _pred suffix on those fields
    typedef struct packed {
        logic [31:0]                 pc;
        logic                        taken;
        logic                        local_pred;
        logic                        global_pred;
        logic [BPRED_LHIST_BITS-1:0] lhist;
        logic [BPRED_GHIST_BITS-1:0] ghist;
        logic                        mispredict;
    } bpred_upd_t;

    localparam selector_t SEL2_RESET = local_lt;

    function automatic int unsigned ctr_reset_val(input int unsigned bits);
        return (2 ** (bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/bpred_table.sv
// DEPTH x WIDTH saturating-counter array: one combinational MSB read port and
// one saturating increment/decrement write port.
module bpred_table
    import rv32i_types::*;
#(
    parameter int unsigned           IDX_BITS  = 4,
    parameter int unsigned           WIDTH     = 2,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic                rd_msb_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_inc_i
);

    localparam int unsigned DEPTH = 2 ** IDX_BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] wr_d;

    assign rd_msb_o = mem_q[rd_idx_i][WIDTH-1];

    always_comb begin
        wr_cur = mem_q[wr_idx_i];
        wr_d   = wr_cur;
        if (wr_inc_i) begin
            if (wr_cur != '1) begin
                wr_d = wr_cur + 1'b1;
            end
        end else begin
            if (wr_cur != '0) begin
                wr_d = wr_cur - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: RESET_VAL};
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_d;
        end
    end

endmodule

// File: rtl/tournament_bpred.sv
// Tournament branch predictor: local-history PHT, gshare PHT and per-PC chooser,
// with speculative global history restored on mispredict.
module tournament_bpred
    import rv32i_types::*;
#(
    parameter int unsigned PC_IDX_BITS = 6,
    parameter int unsigned LHIST_BITS  = 4,
    parameter int unsigned GHIST_BITS  = 8,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned SEL_BITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic [31:0]           pred_pc,
    output logic                  pred_taken,
    output logic                  pred_local,
    output logic                  pred_global,
    output logic [LHIST_BITS-1:0] pred_lhist,
    output logic [GHIST_BITS-1:0] pred_ghist,
    input  logic                  upd_valid,
    input  logic [31:0]           upd_pc,
    input  logic                  upd_taken,
    input  logic                  upd_local,
    input  logic                  upd_global,
    input  logic [LHIST_BITS-1:0] upd_lhist,
    input  logic [GHIST_BITS-1:0] upd_ghist,
    input  logic                  upd_mispredict
);

    localparam int unsigned LHT_DEPTH = 2 ** PC_IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
    localparam logic [SEL_BITS-1:0] SEL_RST = (SEL_BITS == 2) ? SEL_BITS'(SEL2_RESET)
                                                              : SEL_BITS'(ctr_reset_val(SEL_BITS));

    logic [LHIST_BITS-1:0]  lht_q [LHT_DEPTH];
    logic [GHIST_BITS-1:0]  ghr_q;
    logic [GHIST_BITS-1:0]  ghr_d;

    logic [PC_IDX_BITS-1:0] pred_li;
    logic [GHIST_BITS-1:0]  pred_gi;
    logic [PC_IDX_BITS-1:0] upd_li;
    logic [GHIST_BITS-1:0]  upd_gi;
    logic                   sel_global;
    logic                   sel_wr_en;
    logic                   unused_pc;

    assign unused_pc = ^{pred_pc, upd_pc};

    assign pred_li = pred_pc[PC_IDX_BITS+1:2];
    assign pred_gi = pred_pc[GHIST_BITS+1:2] ^ ghr_q;
    assign upd_li  = upd_pc[PC_IDX_BITS+1:2];
    assign upd_gi  = upd_pc[GHIST_BITS+1:2] ^ upd_ghist;

    assign pred_lhist = lht_q[pred_li];
    assign pred_ghist = ghr_q;
    assign pred_taken = sel_global ? pred_global : pred_local;

    // Chooser only learns when the components disagreed; moves toward the correct one
    assign sel_wr_en = upd_valid && (upd_local != upd_global);

    bpred_table #(
        .IDX_BITS  (LHIST_BITS),
        .WIDTH     (CTR_BITS),
        .RESET_VAL (CTR_RST)
    ) u_lpht (
        .clk_i    (clk),
        .rst_ni   (rst),
        .rd_idx_i (pred_lhist),
        .rd_msb_o (pred_local),
        .wr_en_i  (upd_valid),
        .wr_idx_i (upd_lhist),
        .wr_inc_i (upd_taken)
    );

    bpred_table #(
        .IDX_BITS  (GHIST_BITS),
        .WIDTH     (CTR_BITS),
        .RESET_VAL (CTR_RST)
    ) u_gpht (
        .clk_i    (clk),
        .rst_ni   (rst),
        .rd_idx_i (pred_gi),
        .rd_msb_o (pred_global),
        .wr_en_i  (upd_valid),
        .wr_idx_i (upd_gi),
        .wr_inc_i (upd_taken)
    );

    bpred_table #(
        .IDX_BITS  (PC_IDX_BITS),
        .WIDTH     (SEL_BITS),
        .RESET_VAL (SEL_RST)
    ) u_chooser (
        .clk_i    (clk),
        .rst_ni   (rst),
        .rd_idx_i (pred_li),
        .rd_msb_o (sel_global),
        .wr_en_i  (sel_wr_en),
        .wr_idx_i (upd_li),
        .wr_inc_i (upd_global == upd_taken)
    );

    // Mispredict recovery outranks speculation; a same-cycle prediction is wrong-path
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid && upd_mispredict) begin
            ghr_d = {upd_ghist[GHIST_BITS-2:0], upd_taken};
        end else if (pred_valid) begin
            ghr_d = {ghr_q[GHIST_BITS-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
            lht_q <= '{default: '0};
        end else begin
            ghr_q <= ghr_d;
            if (upd_valid) begin
                lht_q[upd_li] <= {upd_lhist[LHIST_BITS-2:0], upd_taken};
            end
        end
    end

endmodule

// File: tb/tb_tournament_bpred.sv
// Self-checking bench for tournament_bpred: directed scenarios plus randomized
// traffic against an array-based behavioural model.
module tb_tournament_bpred;
    import rv32i_types::*;

    localparam int PCB = 6;
    localparam int LHB = 4;
    localparam int GHB = 8;
    localparam int CTR_MAX = 3;
    localparam int SEL_MAX = 3;

    logic           clk;
    logic           rst;
    logic           pred_valid;
    logic [31:0]    pred_pc;
    logic           pred_taken;
    logic           pred_local;
    logic           pred_global;
    logic [LHB-1:0] pred_lhist;
    logic [GHB-1:0] pred_ghist;
    logic           upd_valid;
    bpred_upd_t     upd;

    int vectors;
    int miscompares;

    int m_lpht [1<<LHB];
    int m_gpht [1<<GHB];
    int m_sel  [1<<PCB];
    int m_lht  [1<<PCB];
    int m_ghr;

    tournament_bpred #(
        .PC_IDX_BITS (PCB),
        .LHIST_BITS  (LHB),
        .GHIST_BITS  (GHB),
        .CTR_BITS    (2),
        .SEL_BITS    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_local     (pred_local),
        .pred_global    (pred_global),
        .pred_lhist     (pred_lhist),
        .pred_ghist     (pred_ghist),
        .upd_valid      (upd_valid),
        .upd_pc         (upd.pc),
        .upd_taken      (upd.taken),
        .upd_local      (upd.local_pred),
        .upd_global     (upd.global_pred),
        .upd_lhist      (upd.lhist),
        .upd_ghist      (upd.ghist),
        .upd_mispredict (upd.mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v, input bit up, input int maxv);
        if (up) return (v < maxv) ? v + 1 : v;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic model_reset();
        foreach (m_lpht[i]) m_lpht[i] = 1;
        foreach (m_gpht[i]) m_gpht[i] = 1;
        foreach (m_sel[i])  m_sel[i]  = 1;
        foreach (m_lht[i])  m_lht[i]  = 0;
        m_ghr = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic t, output logic l,
                                 output logic g, output int lh, output int gh);
        int li, gi;
        li = int'(pc >> 2) % (1 << PCB);
        gi = (int'(pc >> 2) % (1 << GHB)) ^ m_ghr;
        lh = m_lht[li];
        gh = m_ghr;
        l  = (m_lpht[lh] >= 2);
        g  = (m_gpht[gi] >= 2);
        t  = (m_sel[li] >= 2) ? g : l;
    endtask

    // Applies one clock edge's worth of architectural effect from current inputs
    task automatic model_edge();
        logic t, l, g;
        int lh, gh, li, gi, lhist, ghist;
        model_predict(pred_pc, t, l, g, lh, gh);
        lhist = int'(upd.lhist);
        ghist = int'(upd.ghist);
        if (upd_valid && upd.mispredict)
            m_ghr = ((ghist * 2) + int'(upd.taken)) % (1 << GHB);
        else if (pred_valid)
            m_ghr = ((m_ghr * 2) + int'(t)) % (1 << GHB);
        if (upd_valid) begin
            li = int'(upd.pc >> 2) % (1 << PCB);
            gi = (int'(upd.pc >> 2) % (1 << GHB)) ^ ghist;
            m_lpht[lhist] = sat(m_lpht[lhist], upd.taken, CTR_MAX);
            m_gpht[gi]    = sat(m_gpht[gi], upd.taken, CTR_MAX);
            m_lht[li]     = ((lhist * 2) + int'(upd.taken)) % (1 << LHB);
            if (upd.local_pred != upd.global_pred)
                m_sel[li] = sat(m_sel[li], upd.global_pred == upd.taken, SEL_MAX);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk, input logic lo,
                           input logic gl, input logic [LHB-1:0] lh, input logic [GHB-1:0] gh,
                           input logic mis);
        upd_valid       = v;
        upd.pc          = pc;
        upd.taken       = tk;
        upd.local_pred  = lo;
        upd.global_pred = gl;
        upd.lhist       = lh;
        upd.ghist       = gh;
        upd.mispredict  = mis;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pred_valid = 1'b0;
        pred_pc = 32'h60;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        model_reset();
        #1;
        vectors += 5;
        if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
        if (pred_local !== 1'b0) begin miscompares++; $display("FAIL reset_local got=%b exp=0", pred_local); end
        if (pred_global !== 1'b0) begin miscompares++; $display("FAIL reset_global got=%b exp=0", pred_global); end
        if (pred_ghist !== 8'h00) begin miscompares++; $display("FAIL reset_ghist got=%h exp=00", pred_ghist); end
        if (pred_lhist !== 4'h0) begin miscompares++; $display("FAIL reset_lhist got=%h exp=0", pred_lhist); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_training();
        set_upd(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        repeat (3) step();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        pred_pc = 32'h60;
        #1;
        vectors += 4;
        if (pred_global !== 1'b1) begin miscompares++; $display("FAIL train_global got=%b exp=1", pred_global); end
        if (pred_lhist !== 4'h1) begin miscompares++; $display("FAIL train_lhist got=%h exp=1", pred_lhist); end
        if (pred_local !== 1'b0) begin miscompares++; $display("FAIL train_local got=%b exp=0", pred_local); end
        if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL train_taken got=%b exp=0", pred_taken); end
    endtask

    task automatic test_chooser();
        set_upd(1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 4'h5, 8'h55, 1'b0);
        repeat (2) step();
        upd_valid = 1'b0;
        #1;
        vectors += 3;
        if (pred_lhist !== 4'hA) begin miscompares++; $display("FAIL chooser_lhist got=%h exp=a", pred_lhist); end
        if (pred_local !== 1'b0) begin miscompares++; $display("FAIL chooser_local got=%b exp=0", pred_local); end
        if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL chooser_to_global got=%b exp=1", pred_taken); end
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        #1;
        vectors++;
        if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL chooser_saturate got=%b exp=1", pred_taken); end
    endtask

    task automatic test_recovery();
        logic [GHB-1:0] exp_gh;
        set_upd(1'b1, 32'h60, 1'b1, 1'b1, 1'b1, 4'h5, 8'h01, 1'b0);
        repeat (2) step();
        upd.ghist = 8'h03;
        repeat (2) step();
        upd_valid = 1'b0;
        pred_pc = 32'h60;
        pred_valid = 1'b1;
        exp_gh = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors += 2;
            if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL recov_spec_taken[%0d] got=%b exp=1", i, pred_taken); end
            if (pred_ghist !== exp_gh) begin miscompares++; $display("FAIL recov_spec_ghist[%0d] got=%h exp=%h", i, pred_ghist, exp_gh); end
            step();
            exp_gh = {exp_gh[GHB-2:0], 1'b1};
        end
        #1;
        vectors++;
        if (pred_ghist !== 8'h07) begin miscompares++; $display("FAIL recov_ghr7 got=%h exp=07", pred_ghist); end
        set_upd(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 4'h2, 8'h01, 1'b1);
        step();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        pred_valid = 1'b0;
        #1;
        vectors++;
        if (pred_ghist !== 8'h02) begin miscompares++; $display("FAIL recov_restore got=%h exp=02", pred_ghist); end
    endtask

    task automatic test_bypass();
        pred_valid = 1'b0;
        pred_pc = 32'h60;
        set_upd(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 4'hB, 8'h00, 1'b0);
        #1;
        vectors += 2;
        if (pred_lhist !== 4'hB) begin miscompares++; $display("FAIL bypass_lhist got=%h exp=b", pred_lhist); end
        if (pred_local !== 1'b0) begin miscompares++; $display("FAIL bypass_old got=%b exp=0", pred_local); end
        step();
        upd_valid = 1'b0;
        #1;
        vectors++;
        if (pred_local !== 1'b1) begin miscompares++; $display("FAIL bypass_new got=%b exp=1", pred_local); end
    endtask

    task automatic test_random();
        logic t, l, g;
        int lh, gh;
        for (int n = 0; n < 400; n++) begin
            pred_valid = ($urandom_range(0, 2) != 0);
            pred_pc    = 32'h40 + ($urandom_range(0, 15) << 2);
            set_upd($urandom_range(0, 9) < 7, 32'h40 + ($urandom_range(0, 15) << 2),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    LHB'($urandom), GHB'($urandom_range(0, 7)), $urandom_range(0, 5) == 0);
            #1;
            model_predict(pred_pc, t, l, g, lh, gh);
            vectors += 5;
            if (pred_taken !== t) begin miscompares++; $display("FAIL rnd_taken[%0d] got=%b exp=%b", n, pred_taken, t); end
            if (pred_local !== l) begin miscompares++; $display("FAIL rnd_local[%0d] got=%b exp=%b", n, pred_local, l); end
            if (pred_global !== g) begin miscompares++; $display("FAIL rnd_global[%0d] got=%b exp=%b", n, pred_global, g); end
            if (pred_lhist !== LHB'(lh)) begin miscompares++; $display("FAIL rnd_lhist[%0d] got=%h exp=%h", n, pred_lhist, lh); end
            if (pred_ghist !== GHB'(gh)) begin miscompares++; $display("FAIL rnd_ghist[%0d] got=%h exp=%h", n, pred_ghist, gh); end
            step();
        end
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        pred_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        set_upd(1'b1, 32'h60, 1'b1, 1'b0, 1'b1, 4'h7, 8'h00, 1'b0);
        pred_valid = 1'b1;
        pred_pc = 32'h60;
        repeat (4) step();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        pred_valid = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vectors += 5;
        if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL arst_taken got=%b exp=0", pred_taken); end
        if (pred_local !== 1'b0) begin miscompares++; $display("FAIL arst_local got=%b exp=0", pred_local); end
        if (pred_global !== 1'b0) begin miscompares++; $display("FAIL arst_global got=%b exp=0", pred_global); end
        if (pred_lhist !== 4'h0) begin miscompares++; $display("FAIL arst_lhist got=%h exp=0", pred_lhist); end
        if (pred_ghist !== 8'h00) begin miscompares++; $display("FAIL arst_ghist got=%h exp=00", pred_ghist); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_training();
        test_chooser();
        test_recovery();
        test_bypass();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
